// File: rtl/cc_unit.sv
// cc_unit: LC-3 condition-code unit.
// Holds the one-hot N/Z/P condition codes loaded from the bus, the branch-enable
// flag, and a small LIFO of saved condition codes used on interrupt entry/return.
// Optional feature: define CC_ERR_EN to add the sticky cc_err misuse flag port.
module cc_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       IR_nzp,
    input  logic             CC_PUSH,
    input  logic             CC_POP,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             BEN,
    output logic [PTR_W-1:0] stack_count,
    output logic             stack_full,
`ifdef CC_ERR_EN
    output logic             stack_empty,
    output logic             cc_err
`else
    output logic             stack_empty
`endif
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]       cc_q;
    logic [2:0]       load_nzp;
    logic [2:0]       stack_mem [DEPTH];
    logic             push_req;
    logic             pop_req;
    logic             do_push;
    logic             do_pop;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    // Decode the bus value into a one-hot {n,z,p}; a set sign bit is never zero.
    always_comb begin
        load_nzp = 3'b001;
        if (Data == '0) begin
            load_nzp = 3'b010;
        end else if (Data[WIDTH-1]) begin
            load_nzp = 3'b100;
        end
    end

    // Simultaneous push and pop cancel; overflow/underflow requests are dropped.
    always_comb begin
        push_req = CC_PUSH & ~CC_POP;
        pop_req  = CC_POP & ~CC_PUSH;
        do_push  = push_req & ~stack_full;
        do_pop   = pop_req & ~stack_empty;
        push_idx = IDX_W'(stack_count);
        pop_idx  = IDX_W'(stack_count - PTR_W'(1));
    end

    // Condition codes, branch enable and stack depth; a valid pop beats LD_CC.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cc_q        <= 3'b010;
            BEN         <= 1'b0;
            stack_count <= '0;
        end else begin
            if (do_pop) begin
                cc_q <= stack_mem[pop_idx];
            end else if (LD_CC) begin
                cc_q <= load_nzp;
            end
            if (LD_BEN) begin
                BEN <= |(IR_nzp & cc_q);
            end
            if (do_push) begin
                stack_count <= stack_count + PTR_W'(1);
            end else if (do_pop) begin
                stack_count <= stack_count - PTR_W'(1);
            end
        end
    end

    // Save-stack storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge Clk) begin
        if (do_push && !Reset) begin
            stack_mem[push_idx] <= cc_q;
        end
    end

`ifdef CC_ERR_EN
    // Sticky misuse flag: overflow, underflow or conflicting push/pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cc_err <= 1'b0;
        end else if ((CC_PUSH & CC_POP) | (push_req & stack_full) | (pop_req & stack_empty)) begin
            cc_err <= 1'b1;
        end
    end
`endif

    // Output decode of the held condition codes and stack occupancy.
    always_comb begin
        {n, z, p}   = cc_q;
        stack_full  = (stack_count == PTR_W'(DEPTH));
        stack_empty = (stack_count == '0);
    end

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit (default parameters WIDTH=16, DEPTH=4).
module tb_cc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Data;
    logic        LD_CC;
    logic        LD_BEN;
    logic [2:0]  IR_nzp;
    logic        CC_PUSH;
    logic        CC_POP;
    logic        n, z, p;
    logic        BEN;
    logic [2:0]  stack_count;
    logic        stack_full;
    logic        stack_empty;
`ifdef CC_ERR_EN
    logic        cc_err;
`endif

    int vecs = 0;
    int errs = 0;

    cc_unit #(.WIDTH(16), .DEPTH(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Data        (Data),
        .LD_CC       (LD_CC),
        .LD_BEN      (LD_BEN),
        .IR_nzp      (IR_nzp),
        .CC_PUSH     (CC_PUSH),
        .CC_POP      (CC_POP),
        .n           (n),
        .z           (z),
        .p           (p),
        .BEN         (BEN),
        .stack_count (stack_count),
        .stack_full  (stack_full),
`ifdef CC_ERR_EN
        .stack_empty (stack_empty),
        .cc_err      (cc_err)
`else
        .stack_empty (stack_empty)
`endif
    );

    always #5 Clk = ~Clk;

    // Clear strobes.
    task automatic idle();
        Reset = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0; CC_PUSH = 1'b0; CC_POP = 1'b0;
        Data = 16'h0000; IR_nzp = 3'b000;
    endtask

    // Apply the currently driven inputs for one edge, then settle and clear strobes.
    task automatic step();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        step();
    endtask

    task automatic load(input logic [15:0] d);
        LD_CC = 1'b1; Data = d;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if ({n, z, p} !== 3'b010) begin errs++; $display("FAIL reset_nzp: got %b want 010", {n, z, p}); end
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL reset_ben: got %b want 0", BEN); end
        vecs++; if (stack_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", stack_count); end
        vecs++; if ({stack_empty, stack_full} !== 2'b10) begin errs++; $display("FAIL reset_flags: got %b want 10", {stack_empty, stack_full}); end
`ifdef CC_ERR_EN
        vecs++; if (cc_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", cc_err); end
`endif
    endtask

    task automatic test_cc_load();
        load(16'h8001);
        vecs++; if ({n, z, p} !== 3'b100) begin errs++; $display("FAIL load_8001: got %b want 100", {n, z, p}); end
        load(16'h0000);
        vecs++; if ({n, z, p} !== 3'b010) begin errs++; $display("FAIL load_0000: got %b want 010", {n, z, p}); end
        LD_CC = 1'b1; Data = 16'h7FFF;
        #1;
        vecs++; if ({n, z, p} !== 3'b010) begin errs++; $display("FAIL load_latency: got %b want 010", {n, z, p}); end
        step();
        vecs++; if ({n, z, p} !== 3'b001) begin errs++; $display("FAIL load_7fff: got %b want 001", {n, z, p}); end
        load(16'hFFFF);
        vecs++; if ({n, z, p} !== 3'b100) begin errs++; $display("FAIL load_ffff: got %b want 100", {n, z, p}); end
    endtask

    task automatic test_ben();
        load(16'h0001);
        LD_BEN = 1'b1; IR_nzp = 3'b011;
        step();
        vecs++; if (BEN !== 1'b1) begin errs++; $display("FAIL ben_011: got %b want 1", BEN); end
        LD_BEN = 1'b1; IR_nzp = 3'b100;
        step();
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL ben_100: got %b want 0", BEN); end
        LD_CC = 1'b1; Data = 16'h8000; LD_BEN = 1'b1; IR_nzp = 3'b100;
        step();
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL ben_old_cc: got %b want 0", BEN); end
        vecs++; if ({n, z, p} !== 3'b100) begin errs++; $display("FAIL ben_new_nzp: got %b want 100", {n, z, p}); end
        LD_BEN = 1'b1; IR_nzp = 3'b100;
        step();
        vecs++; if (BEN !== 1'b1) begin errs++; $display("FAIL ben_new_cc: got %b want 1", BEN); end
        LD_BEN = 1'b1; IR_nzp = 3'b000;
        step();
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL ben_000: got %b want 0", BEN); end
        IR_nzp = 3'b111;
        step();
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL ben_hold: got %b want 0", BEN); end
    endtask

    task automatic test_reset_mid();
        load(16'h7FFF);
        LD_BEN = 1'b1; IR_nzp = 3'b001;
        step();
        CC_PUSH = 1'b1;
        step();
        Reset = 1'b1; LD_CC = 1'b1; Data = 16'h8000; CC_PUSH = 1'b1; LD_BEN = 1'b1; IR_nzp = 3'b111;
        step();
        vecs++; if ({n, z, p} !== 3'b010) begin errs++; $display("FAIL midreset_nzp: got %b want 010", {n, z, p}); end
        vecs++; if (BEN !== 1'b0) begin errs++; $display("FAIL midreset_ben: got %b want 0", BEN); end
        vecs++; if ({stack_count, stack_empty} !== 4'b0001) begin errs++; $display("FAIL midreset_stack: got count %0d empty %b want 0 1", stack_count, stack_empty); end
    endtask

    task automatic test_push_pop();
        logic [15:0] vals [4];
        logic [2:0]  exp_cc [4];
        vals[0] = 16'h0001; vals[1] = 16'h8000; vals[2] = 16'h0000; vals[3] = 16'h1234;
        exp_cc[0] = 3'b001; exp_cc[1] = 3'b100; exp_cc[2] = 3'b010; exp_cc[3] = 3'b001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(vals[i]);
            CC_PUSH = 1'b1;
            step();
            vecs++; if (stack_count !== 3'(i + 1)) begin errs++; $display("FAIL push_count%0d: got %0d want %0d", i, stack_count, i + 1); end
        end
        vecs++; if ({stack_full, stack_empty} !== 2'b10) begin errs++; $display("FAIL full_flags: got %b want 10", {stack_full, stack_empty}); end
        CC_PUSH = 1'b1;
        step();
        vecs++; if (stack_count !== 3'd4) begin errs++; $display("FAIL push_overflow: got %0d want 4", stack_count); end
        vecs++; if ({n, z, p} !== 3'b001) begin errs++; $display("FAIL overflow_cc: got %b want 001", {n, z, p}); end
`ifdef CC_ERR_EN
        vecs++; if (cc_err !== 1'b1) begin errs++; $display("FAIL overflow_err: got %b want 1", cc_err); end
`endif
        load(16'h8000);
        for (int i = 3; i >= 0; i--) begin
            CC_POP = 1'b1;
            step();
            vecs++; if ({n, z, p} !== exp_cc[i]) begin errs++; $display("FAIL pop_cc%0d: got %b want %b", i, {n, z, p}, exp_cc[i]); end
            vecs++; if (stack_count !== 3'(i)) begin errs++; $display("FAIL pop_count%0d: got %0d want %0d", i, stack_count, i); end
        end
        vecs++; if ({stack_full, stack_empty} !== 2'b01) begin errs++; $display("FAIL empty_flags: got %b want 01", {stack_full, stack_empty}); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        CC_POP = 1'b1; LD_CC = 1'b1; Data = 16'h0001;
        step();
        vecs++; if ({n, z, p} !== 3'b001) begin errs++; $display("FAIL underflow_cc: got %b want 001", {n, z, p}); end
        vecs++; if (stack_count !== 3'd0) begin errs++; $display("FAIL underflow_count: got %0d want 0", stack_count); end
`ifdef CC_ERR_EN
        vecs++; if (cc_err !== 1'b1) begin errs++; $display("FAIL underflow_err: got %b want 1", cc_err); end
        step();
        vecs++; if (cc_err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", cc_err); end
`endif
    endtask

    task automatic test_pop_wins();
        do_reset();
        load(16'h8000);
        CC_PUSH = 1'b1;
        step();
        load(16'h0001);
        CC_POP = 1'b1; LD_CC = 1'b1; Data = 16'h0000;
        step();
        vecs++; if ({n, z, p} !== 3'b100) begin errs++; $display("FAIL pop_wins_cc: got %b want 100", {n, z, p}); end
        vecs++; if (stack_count !== 3'd0) begin errs++; $display("FAIL pop_wins_count: got %0d want 0", stack_count); end
`ifdef CC_ERR_EN
        vecs++; if (cc_err !== 1'b0) begin errs++; $display("FAIL pop_wins_err: got %b want 0", cc_err); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(16'h0001);
        CC_PUSH = 1'b1;
        step();
        load(16'h8000);
        CC_PUSH = 1'b1; CC_POP = 1'b1;
        step();
        vecs++; if (stack_count !== 3'd1) begin errs++; $display("FAIL pushpop_count: got %0d want 1", stack_count); end
        vecs++; if ({n, z, p} !== 3'b100) begin errs++; $display("FAIL pushpop_cc: got %b want 100", {n, z, p}); end
`ifdef CC_ERR_EN
        vecs++; if (cc_err !== 1'b1) begin errs++; $display("FAIL pushpop_err: got %b want 1", cc_err); end
`endif
        CC_PUSH = 1'b1; CC_POP = 1'b1; LD_CC = 1'b1; Data = 16'h0000;
        step();
        vecs++; if ({stack_count, n, z, p} !== {3'd1, 3'b010}) begin errs++; $display("FAIL pushpop_ld: got count %0d nzp %b want 1 010", stack_count, {n, z, p}); end
        CC_PUSH = 1'b1; LD_CC = 1'b1; Data = 16'h7FFF;
        step();
        vecs++; if ({stack_count, n, z, p} !== {3'd2, 3'b001}) begin errs++; $display("FAIL push_ld: got count %0d nzp %b want 2 001", stack_count, {n, z, p}); end
        CC_POP = 1'b1;
        step();
        vecs++; if ({stack_count, n, z, p} !== {3'd1, 3'b010}) begin errs++; $display("FAIL pop_after_ld: got count %0d nzp %b want 1 010", stack_count, {n, z, p}); end
        CC_POP = 1'b1;
        step();
        vecs++; if ({stack_count, n, z, p} !== {3'd0, 3'b001}) begin errs++; $display("FAIL pop_last: got count %0d nzp %b want 0 001", stack_count, {n, z, p}); end
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        #2;
        test_reset();
        test_cc_load();
        test_ben();
        test_reset_mid();
        test_push_pop();
        test_pop_empty();
        test_pop_wins();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
